// File: rtl/demux1024_wr_n.sv
// ---------------------------------------------------------------------------
// demux1024_wr_n
//
// Pipelined 1-to-1024 write distributor feeding a registered storage bank.
// A write is accepted on a rising edge where we_i && ready_o. The first stage
// registers a one-hot group decode of sel[9:5], plus sel[4:0] and the data.
// The second stage commits the word to exactly one entry and pulses done_o
// for one cycle. All 1024 entries are exposed in parallel on data_o.
//
// Ports:
//   clk_i    in   1        clock, rising edge
//   rst_i    in   1        synchronous active-high reset
//   we_i     in   1        write request
//   clr_i    in   1        clear-all request (only with DEMUX1024_CLR_EN)
//   sel      in   address  target entry index
//   data_i   in   n        write data
//   ready_o  out  1        a request can be accepted this cycle
//   done_o   out  1        one-cycle pulse when a write reaches the bank
//   data_o   out  n x 1024 registered entries
//
// Build option:
//   DEMUX1024_CLR_EN  adds clr_i and an IDLE/CLEAR FSM that sweeps the bank
//                     to zero one 32-entry group per cycle. Without it
//                     ready_o is tied high.
// ---------------------------------------------------------------------------
module demux1024_wr_n #(
    parameter int n       = 4,
    parameter int address = 10,
    parameter int m       = 32,
    parameter int gr      = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
`ifdef DEMUX1024_CLR_EN
    input  logic               clr_i,
`endif
    input  logic [address-1:0] sel,
    input  logic [n-1:0]       data_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [n-1:0]       data_o [0:1023]
);

    localparam int Entries = m * gr;
    localparam int IdxW    = $clog2(m);
    localparam int GrpW    = $clog2(gr);

    logic              accept;
    logic              v1_q;
    logic [gr-1:0]     grpHot_q;
    logic [IdxW-1:0]   idx_q;
    logic [n-1:0]      data1_q;
    logic              done_q;
    logic [n-1:0]      bank_q [0:Entries-1];

`ifdef DEMUX1024_CLR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [GrpW-1:0]   gc_q;
    logic [GrpW-1:0]   gc_d;
    logic              ready_q;

    // Next-state logic: a clear request in IDLE starts a sweep from group 0;
    // the sweep ends after the last group has been zeroed. clr_i is ignored
    // while a sweep is already running.
    always_comb begin
        state_d = state_q;
        gc_d    = gc_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    gc_d    = '0;
                end
            end
            CLEAR: begin
                gc_d = gc_q + GrpW'(1);
                if (gc_q == GrpW'(gr - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. ready is registered from the next state so that it
    // drops the cycle after the clear request and rises the cycle after the
    // final group is swept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gc_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            gc_q    <= gc_d;
            ready_q <= (state_d == IDLE);
        end
    end

    assign ready_o = ready_q;
`else
    assign ready_o = 1'b1;
`endif

    assign accept = we_i && ready_o;

    // Stage 1: capture the request. The group field is decoded to one-hot
    // here so stage 2 only has to combine one group line with the index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q     <= 1'b0;
            done_q   <= 1'b0;
            grpHot_q <= '0;
            idx_q    <= '0;
            data1_q  <= '0;
        end else begin
            v1_q   <= accept;
            done_q <= v1_q;
            if (accept) begin
                grpHot_q <= gr'(1) << sel[address-1:IdxW];
                idx_q    <= sel[IdxW-1:0];
                data1_q  <= data_i;
            end
        end
    end

    // Stage 2: commit to the bank. The clear sweep is written after the
    // commit so that, when both hit the same group on one edge, zero wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < Entries; e++) begin
                bank_q[e] <= '0;
            end
        end else begin
            if (v1_q) begin
                for (int g = 0; g < gr; g++) begin
                    if (grpHot_q[g]) begin
                        bank_q[{GrpW'(g), idx_q}] <= data1_q;
                    end
                end
            end
`ifdef DEMUX1024_CLR_EN
            if (state_q == CLEAR) begin
                for (int j = 0; j < m; j++) begin
                    bank_q[{gc_q, IdxW'(j)}] <= '0;
                end
            end
`endif
        end
    end

    assign done_o = done_q;
    assign data_o = bank_q;

endmodule
